serial_adder: RTL and testbench

// - Bit-serial ripple adder that feeds one full-adder cell (fa_cell) with

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_if.sv | 43 ++++
 rtl/fa_cell.sv | 13 +
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width able to hold 0..w
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for serial_adder.
// Optional macro SERIAL_ADDER_SUBTRACT_EN adds the 'sub' request bit.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    // Requester side: supplies operands, consumes the result
    modport master (
        output start_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
        output sub,
`endif
        output done_ready,
        input  start_ready, sum, cout, done_valid, busy
    );

    // Adder side
    modport slave (
        input  start_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
        input  sub,
`endif
        input  done_ready,
        output start_ready, sum, cout, done_valid, busy
    );

endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder.
module fa_cell (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y,
    input  logic z
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, carry kept in a flop.
// Optional macro SERIAL_ADDER_SUBTRACT_EN enables a-b via the 'sub' bit.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done_valid;
    logic             r_start_ready;
    logic             r_busy;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    // Operand conditioning at load: subtraction is a + ~b + 1
`ifdef SERIAL_ADDER_SUBTRACT_EN
    assign w_b_load = bus.sub ? ~bus.b : bus.b;
    assign w_c_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_b_load = bus.b;
    assign w_c_load = bus.cin;
`endif

    fa_cell u_fa (
        .s (w_s),
        .c (w_c),
        .x (r_a_sr[0]),
        .y (r_b_sr[0]),
        .z (r_carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB
    assign w_sum_next = WIDTH'({w_s, r_sum_sr} >> 1);

    // Control FSM with datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_a_sr        <= '0;
            r_b_sr        <= '0;
            r_sum_sr      <= '0;
            r_carry       <= 1'b0;
            r_cnt         <= '0;
            r_sum         <= '0;
            r_cout        <= 1'b0;
            r_done_valid  <= 1'b0;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_start_ready <= 1'b1;
                    if (bus.start_valid && r_start_ready) begin
                        r_a_sr        <= bus.a;
                        r_b_sr        <= w_b_load;
                        r_carry       <= w_c_load;
                        r_cnt         <= '0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_sum        <= w_sum_next;
                        r_cout       <= w_c;
                        r_done_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.sum         = r_sum;
    assign bus.cout        = r_cout;
    assign bus.done_valid  = r_done_valid;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

    localparam int unsigned W   = 8;
    localparam int          LAT = W + 1;

    logic clk;
    logic rst_n;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference arithmetic: {cout,sum}
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic sb);
        if (sb) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    function automatic logic cur_sub();
`ifdef SERIAL_ADDER_SUBTRACT_EN
        return bus.sub;
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level model: readiness, pending op, countdown, last result
    bit         m_rdy  = 0;
    bit         m_pend = 0;
    bit         m_done = 0;
    int         m_left = 0;
    logic [W:0] m_exp  = '0;
    logic [W:0] m_last = '0;

    // Compare every cycle, then predict what the next rising edge does
    always @(negedge clk) begin
        if (!rst_n) begin
            m_rdy = 0; m_pend = 0; m_done = 0; m_left = 0; m_last = '0;
        end
        chk("mon_start_ready", 32'(bus.start_ready), 32'(m_rdy));
        chk("mon_busy",        32'(bus.busy),        32'(m_pend));
        chk("mon_done_valid",  32'(bus.done_valid),  32'(m_done));
        chk("mon_result",      32'({bus.cout, bus.sum}), 32'(m_last));
        if (rst_n) begin
            if (m_done) begin
                if (bus.done_ready) begin
                    m_done = 0; m_pend = 0; m_rdy = 1;
                end
            end else if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_last = m_exp;
                end
            end else if (m_rdy && bus.start_valid) begin
                m_pend = 1; m_rdy = 0; m_left = W;
                m_exp  = model_add(bus.a, bus.b, bus.cin, cur_sub());
            end else begin
                m_rdy = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_sub(input logic v);
`ifdef SERIAL_ADDER_SUBTRACT_EN
        bus.sub = v;
`else
        if (v) $display("note: sub ignored in add-only build");
`endif
    endtask

    // One full operation; lat counts edges from the accept edge to done_valid
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic isub, input int hold, input bit noise,
                         output logic [W-1:0] osum, output logic ocout, output int lat);
        int guard;
        guard = 0;
        while (!bus.start_ready && guard < 30) begin
            tick();
            guard++;
        end
        if (!bus.start_ready) chk("wait_start_ready_timeout", 32'(0), 32'(1));
        bus.a = ia; bus.b = ib; bus.cin = icin; set_sub(isub);
        bus.start_valid = 1'b1;
        tick();
        lat = 1;
        bus.start_valid = 1'b0;
        while (!bus.done_valid && lat < 40) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.cin = 1'($urandom);
            if (noise) bus.start_valid = 1'($urandom);
            tick();
            lat++;
        end
        if (!bus.done_valid) chk("wait_done_timeout", 32'(0), 32'(1));
        osum  = bus.sum;
        ocout = bus.cout;
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                bus.start_valid = 1'b1;
                bus.a = W'($urandom);
            end
            tick();
            chk("hold_done_valid",  32'(bus.done_valid),  32'(1));
            chk("hold_start_ready", 32'(bus.start_ready), 32'(0));
            chk("hold_result",      32'({bus.cout, bus.sum}), 32'({ocout, osum}));
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        tick();
        bus.done_ready  = 1'b0;
    endtask

    logic [W-1:0] r_s;
    logic         r_c;
    int           r_lat;
    logic [W-1:0] ta, tb;
    logic         tc, ts;
    logic [W:0]   te;

    initial begin
        rst_n = 1'b0;
        bus.start_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.done_ready = 1'b0;
        set_sub(1'b0);

        // Model pinned against hand-computed sums
        chk("pin_model_a5", 32'(model_add(8'hA5, 8'h5A, 1'b1, 1'b0)), 32'h100);
        chk("pin_model_37", 32'(model_add(8'h37, 8'h29, 1'b0, 1'b0)), 32'h060);
        chk("pin_model_sub", 32'(model_add(8'h10, 8'h01, 1'b0, 1'b1)), 32'h10F);

        repeat (3) tick();
        chk("rst_start_ready", 32'(bus.start_ready), 32'(0));
        chk("rst_outputs", 32'({bus.busy, bus.done_valid, bus.cout, bus.sum}), 32'(0));
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", 32'(bus.start_ready), 32'(1));

        do_op(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, r_s, r_c, r_lat);
        chk("zero_sum", 32'({r_c, r_s}), 32'h000);
        chk("zero_latency", 32'(r_lat), 32'(LAT));

        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 1'b0, r_s, r_c, r_lat);
        chk("ripple_sum", 32'({r_c, r_s}), 32'h100);

        do_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0, 1'b1, r_s, r_c, r_lat);
        chk("a5_5a_sum", 32'({r_c, r_s}), 32'h100);

        do_op(8'h37, 8'h29, 1'b0, 1'b0, 5, 1'b1, r_s, r_c, r_lat);
        chk("37_29_sum_held", 32'({r_c, r_s}), 32'h060);

        // Abort during the 4th SHIFT cycle
        bus.a = 8'hEE; bus.b = 8'h11; bus.cin = 1'b1;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({bus.busy, bus.done_valid, bus.start_ready, bus.cout, bus.sum}), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_ready_after_release", 32'(bus.start_ready), 32'(1));
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0, r_s, r_c, r_lat);
        chk("post_abort_sum", 32'({r_c, r_s}), 32'h046);
        chk("post_abort_latency", 32'(r_lat), 32'(LAT));

`ifdef SERIAL_ADDER_SUBTRACT_EN
        do_op(8'h10, 8'h01, 1'b1, 1'b1, 0, 1'b0, r_s, r_c, r_lat);
        chk("sub_10_01", 32'({r_c, r_s}), 32'h10F);
        do_op(8'h01, 8'h02, 1'b0, 1'b1, 2, 1'b0, r_s, r_c, r_lat);
        chk("sub_01_02", 32'({r_c, r_s}), 32'h0FF);
`endif

        for (int k = 0; k < 150; k++) begin
            ta = W'($urandom);
            tb = W'($urandom);
            tc = 1'($urandom);
`ifdef SERIAL_ADDER_SUBTRACT_EN
            ts = 1'($urandom);
`else
            ts = 1'b0;
`endif
            te = model_add(ta, tb, tc, ts);
            do_op(ta, tb, tc, ts, int'($urandom_range(0, 3)), 1'($urandom), r_s, r_c, r_lat);
            chk("rand_result", 32'({r_c, r_s}), 32'(te));
            chk("rand_latency", 32'(r_lat), 32'(LAT));
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
